// File: rtl/avalon_onchip_ram_pipelined.sv
// Avalon-MM on-chip RAM: byte-enabled writes, pipelined reads with optional
// output register, stall/back-pressure, and a post-reset zero-fill engine.
module avalon_onchip_ram_pipelined #(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 1024,
  parameter int ADDR_W         = 10,
  parameter int REG_OUT        = 0,
  parameter int CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  input  logic                clken,
  input  logic                reset_req,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                waitrequest,
  output logic                init_done
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_addr;
  logic                stall;
  logic                in_range;
  logic                accept;
  logic                wr_acc;
  logic                rd_acc;
  logic                clr_we;
  logic                v1;
  logic [DATA_W-1:0]   d1;
  logic                vl;
  logic [DATA_W-1:0]   dl;
  logic [DATA_W-1:0]   last;
  logic [DATA_W-1:0]   mem [DEPTH];

  // Handshake: a request is taken on a rising edge where chipselect & (read|write)
  // & ~waitrequest; a read+write pair performs only the write and yields no response.
  assign stall       = ~clken | reset_req;
  assign in_range    = {1'b0, address} < DEPTH_X;
  assign waitrequest = (state != READY) | stall;
  assign init_done   = (state == READY);
  assign accept      = chipselect & (read | write) & ~waitrequest;
  assign wr_acc      = accept & write;
  assign rd_acc      = accept & read & ~write;
  assign clr_we      = (state == CLEAR) & ~stall & (CLEAR_ON_RESET != 0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else if (state == CLEAR) begin
      if (CLEAR_ON_RESET == 0) begin
        state <= READY;
      end else if (!stall) begin
        if (clr_addr == LAST) state <= READY;
        else                  clr_addr <= clr_addr + 1'b1;
      end
    end
  end

  // Array has no reset; out-of-range writes are silently dropped.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= CLEAR_VALUE;
    end else if (wr_acc && in_range) begin
      for (int i = 0; i < BE_W; i++) begin
        if (byteenable[i]) mem[address][i*8 +: 8] <= writedata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else if (!stall) begin
      v1 <= rd_acc;
      if (rd_acc) d1 <= in_range ? mem[address] : '0;
    end
  end

  if (REG_OUT != 0) begin : g_reg
    logic              v2;
    logic [DATA_W-1:0] d2;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v2 <= 1'b0;
        d2 <= '0;
      end else if (!stall) begin
        v2 <= v1;
        if (v1) d2 <= d1;
      end
    end
    assign vl = v2;
    assign dl = d2;
  end else begin : g_noreg
    assign vl = v1;
    assign dl = d1;
  end

  // Pipeline data may change while a response is stalled, so the visible
  // readdata is the last delivered word whenever readdatavalid is low.
  assign readdatavalid = vl & ~stall;
  assign readdata      = readdatavalid ? dl : last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           last <= '0;
    else if (readdatavalid) last <= dl;
  end

endmodule

// File: tb/tb_avalon_onchip_ram_pipelined.sv
// Bench for avalon_onchip_ram_pipelined: two instances (read latency 1 and 2)
// share stimulus; a reference memory model feeds per-instance expected queues.
module tb_avalon_onchip_ram_pipelined;

  localparam int DW    = 32;
  localparam int DEPTH = 1000;
  localparam int AW    = 10;
  localparam int BW    = DW / 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] address = '0;
  logic [BW-1:0] byteenable = '0;
  logic          chipselect = 1'b0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [DW-1:0] writedata = '0;
  logic          clken = 1'b1;
  logic          reset_req = 1'b0;

  logic [DW-1:0] rdata0, rdata1;
  logic          rdv0, rdv1, wait0, wait1, idone0, idone1;

  avalon_onchip_ram_pipelined #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .REG_OUT(0),
    .CLEAR_ON_RESET(1), .CLEAR_VALUE('0)) u_lat1 (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .reset_req(reset_req), .readdata(rdata0), .readdatavalid(rdv0),
    .waitrequest(wait0), .init_done(idone0));

  avalon_onchip_ram_pipelined #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .REG_OUT(1),
    .CLEAR_ON_RESET(1), .CLEAR_VALUE('0)) u_lat2 (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .reset_req(reset_req), .readdata(rdata1), .readdatavalid(rdv1),
    .waitrequest(wait1), .init_done(idone1));

  typedef struct packed {
    logic [DW-1:0] data;
    logic [31:0]   due;
  } exp_t;

  exp_t          exp_q0[$];
  exp_t          exp_q1[$];
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] last0 = '0;
  logic [DW-1:0] last1 = '0;
  int            errors = 0;
  int            checks = 0;
  int            ucyc = 0;
  int            clr_cnt = 0;
  logic          accepted = 1'b0;

  // ---------------- clock/reset bookkeeping ----------------
  // ucyc counts unstalled edges; clr_cnt counts unstalled edges since reset release.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_cnt <= 0;
    end else if (clken && !reset_req) begin
      ucyc <= ucyc + 1;
      if (clr_cnt < DEPTH) clr_cnt <= clr_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic cs, input logic rd, input logic wr, input logic [AW-1:0] a,
                      input logic [BW-1:0] be, input logic [DW-1:0] wd, input logic ck,
                      input logic rr);
    logic          exp_wait;
    logic [DW-1:0] rv;
    @(negedge clk);
    #1;
    chipselect = cs; read = rd; write = wr; address = a;
    byteenable = be; writedata = wd; clken = ck; reset_req = rr;
    #1;
    exp_wait = (clr_cnt < DEPTH) || !ck || rr;
    check("waitrequest_lat1", 32'(wait0), 32'(exp_wait));
    check("waitrequest_lat2", 32'(wait1), 32'(exp_wait));
    check("init_done_lat1", 32'(idone0), 32'(clr_cnt == DEPTH));
    check("init_done_lat2", 32'(idone1), 32'(clr_cnt == DEPTH));
    accepted = cs && (rd || wr) && !exp_wait;
    if (accepted) begin
      if (wr) begin
        if (int'(a) < DEPTH) begin
          for (int i = 0; i < BW; i++) if (be[i]) mem_m[a][i*8 +: 8] = wd[i*8 +: 8];
        end
      end else begin
        rv = (int'(a) < DEPTH) ? mem_m[a] : '0;
        exp_q0.push_back('{data: rv, due: 32'(ucyc + 1)});
        exp_q1.push_back('{data: rv, due: 32'(ucyc + 2)});
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic do_read(input int a);
    step(1'b1, 1'b1, 1'b0, AW'(a), '0, '0, 1'b1, 1'b0);
  endtask

  task automatic do_write(input int a, input logic [BW-1:0] be, input logic [DW-1:0] wd);
    step(1'b1, 1'b0, 1'b1, AW'(a), be, wd, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    chipselect = 1'b0; read = 1'b0; write = 1'b0; clken = 1'b1; reset_req = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    last0 = '0;
    last1 = '0;
    #2;
    check("reset_readdata_lat1", rdata0, '0);
    check("reset_readdata_lat2", rdata1, '0);
    check("reset_rdv", 32'({rdv1, rdv0}), 32'(0));
    check("reset_waitrequest", 32'({wait1, wait0}), 32'(3));
    check("reset_init_done", 32'({idone1, idone0}), 32'(0));
    @(negedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (clr_cnt < DEPTH && n < 3000) begin
      idle();
      n++;
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic mon(input int k, input logic v, input logic [DW-1:0] d);
    exp_t e;
    logic empty;
    empty = (k == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
    if (v) begin
      if (empty) begin
        checks++;
        errors++;
        $display("FAIL rdv_unexpected dut%0d: readdatavalid=1 data %h, expected no response at %0t",
                 k, d, $time);
      end else begin
        if (k == 0) e = exp_q0.pop_front();
        else        e = exp_q1.pop_front();
        check($sformatf("readdata_dut%0d", k), d, e.data);
        check($sformatf("latency_dut%0d", k), 32'(ucyc), e.due);
        if (k == 0) last0 = d;
        else        last1 = d;
      end
    end else if (reset_n) begin
      check($sformatf("readdata_hold_dut%0d", k), d, (k == 0) ? last0 : last1);
    end
  endtask

  always begin
    @(negedge clk);
    #4;
    mon(0, rdv0, rdata0);
    mon(1, rdv1, rdata1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int a;
    int t;
    logic ck;

    // Clear with a few stalls, interrupted by reset around word 300.
    do_reset();
    n = 0;
    while (clr_cnt < 300 && n < 1000) begin
      ck = ($urandom_range(0, 7) != 0);
      step(1'b1, 1'b1, 1'b0, AW'($urandom_range(0, 15)), '0, '0, ck, 1'b0);
      n++;
    end
    do_reset();
    n = 0;
    while (!idone0 && n < 3000) begin
      idle();
      n++;
    end
    check("clear_cycles", 32'(n), 32'(DEPTH));

    // Cleared contents.
    do_read(0);
    do_read(511);
    do_read(999);

    // Byte-enable merge.
    do_write(5, 4'b1111, 32'hDEADBEEF);
    do_write(5, 4'b0101, 32'h11223344);
    do_read(5);
    do_write(5, 4'b0000, 32'hFFFFFFFF);
    do_read(5);
    idle();

    // Burst of reads with a 3-cycle clken drop in the middle.
    for (int i = 0; i < 8; i++) do_write(i, 4'hF, $urandom());
    a = 0;
    t = 0;
    while (a < 8 && t < 50) begin
      ck = !(t >= 3 && t < 6);
      step(1'b1, 1'b1, 1'b0, AW'(a), '0, '0, ck, 1'b0);
      if (accepted) a++;
      t++;
    end
    idle();
    idle();

    // reset_req protects contents and delays acceptance.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, AW'(20), 4'hF, 32'hAAAA5555, 1'b1, 1'b1);
    do_read(20);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b1, AW'(20), 4'hF, 32'h5555AAAA, 1'b1, 1'b1);
    do_write(20, 4'hF, 32'h5555AAAA);
    do_read(20);

    // Out-of-range address and read+write collision.
    do_write(999, 4'hF, 32'hCAFEF00D);
    do_write(1010, 4'hF, 32'h12345678);
    do_read(1010);
    do_read(999);
    step(1'b1, 1'b1, 1'b1, AW'(7), 4'hF, 32'h0BADC0DE, 1'b1, 1'b0);
    do_read(7);
    idle();

    // Randomized traffic with stalls.
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(990, 1023) : $urandom_range(0, 15);
      step($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
           AW'(a), BW'($urandom_range(0, 15)), $urandom(),
           $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0);
    end

    // Reset with reads in flight: responses discarded, memory re-cleared.
    do_read(1);
    do_read(2);
    do_reset();
    wait_ready();
    do_read(1);
    do_read(2);
    for (int i = 0; i < 4; i++) idle();

    check("outstanding_lat1", 32'(exp_q0.size()), 32'(0));
    check("outstanding_lat2", 32'(exp_q1.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
